if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 92 +++++++++
 tb/tb_if_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch with BOOT/RUN/HALT control, IF/ID register and fetch counter.
module if_stage #(
  parameter int                WIDTH     = 32,
  parameter int                LOG_DEPTH = 10,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect,
  input  logic [WIDTH-1:0]     redirect_pc,
  input  logic                 halt_req,
  output logic [LOG_DEPTH-1:0] imem_addr,
  input  logic [WIDTH-1:0]     imem_instr,
  output logic [WIDTH-1:0]     id_instr,
  output logic [WIDTH-1:0]     id_pc4,
  output logic                 id_valid,
  output logic                 misalign,
  output logic                 halted,
  output logic [31:0]          fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
  logic             valid_q, valid_d, mis_q, mis_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_inc, tgt;
  assign pc_inc = pc_q + WIDTH'(4);
  assign tgt    = {redirect_pc[WIDTH-1:2], 2'b00};
  // Redirect wins over everything except BOOT, and is the only way out of HALT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (redirect) begin
      state_d = RUN;
      pc_d    = tgt;
      instr_d = '0;
      valid_d = 1'b0;
      mis_d   = mis_q | (|redirect_pc[1:0]);
    end else if (state_q == RUN) begin
      if (halt_req) begin
        state_d = HALT;
        instr_d = '0;
        valid_d = 1'b0;
      end else if (flush) begin
        instr_d = '0;
        valid_d = 1'b0;
        pc_d    = stall ? pc_q : pc_inc;
      end else if (!stall) begin
        instr_d = imem_instr;
        pc4_d   = pc_inc;
        valid_d = 1'b1;
        pc_d    = pc_inc;
        cnt_d   = cnt_q + 32'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end
  assign imem_addr   = pc_q[LOG_DEPTH+1:2];
  assign id_instr    = instr_q;
  assign id_pc4      = pc4_q;
  assign id_valid    = valid_q;
  assign misalign    = mis_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios plus random traffic checked against a fetch reference model.
module tb_if_stage;
  logic        clk = 1'b0, rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0, halt_req = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_instr, id_instr, id_pc4, fetch_count;
  logic        id_valid, misalign, halted;
  logic [31:0] mem [1024];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  bit          m_valid, m_mis, m_halt, m_boot;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid),
    .misalign(misalign), .halted(halted), .fetch_count(fetch_count)
  );

  assign imem_instr = mem[imem_addr];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("imem_addr", 32'(imem_addr), 32'(m_pc[11:2]));
    chk("id_instr", id_instr, m_instr);
    chk("id_pc4", id_pc4, m_pc4);
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_cnt = 0;
    m_valid = 0; m_mis = 0; m_halt = 0; m_boot = 1;
  endtask

  // Behavioural fetch rules; applied with the inputs present before the edge.
  task automatic model_step();
    if (m_boot) m_boot = 0;
    else if (redirect) begin
      m_halt = 0; m_pc = redirect_pc & ~32'd3; m_instr = 0; m_valid = 0;
      if (redirect_pc % 4 != 0) m_mis = 1;
    end else if (m_halt) begin
    end else if (halt_req) begin
      m_halt = 1; m_instr = 0; m_valid = 0;
    end else if (flush) begin
      m_instr = 0; m_valid = 0;
      if (!stall) m_pc = m_pc + 4;
    end else if (!stall) begin
      m_instr = mem[(m_pc / 4) % 1024]; m_pc4 = m_pc + 4; m_valid = 1;
      m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle();
    stall = 0; flush = 0; redirect = 0; halt_req = 0; redirect_pc = '0;
  endtask

  task automatic async_reset();
    @(posedge clk); #3;
    rst = 0; #1;
    model_reset();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    check_all();
    #2 rst = 1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i;
    model_reset();
    #11;
    check_all();
    rst = 1;
    // First edge after release is BOOT: nothing captured.
    cycle();
    chk("boot_valid", 32'(id_valid), 32'd0);
    repeat (3) cycle();
    chk("run_instr", id_instr, 32'd2);
    chk("run_pc4", id_pc4, 32'd12);
    chk("run_count", fetch_count, 32'd3);
    stall = 1; cycle(); cycle();
    chk("stall_addr", 32'(imem_addr), 32'd3);
    chk("stall_count", fetch_count, 32'd3);
    idle(); cycle();
    chk("resume_instr", id_instr, 32'd3);
    chk("resume_count", fetch_count, 32'd4);
    redirect = 1; redirect_pc = 32'h41; stall = 1; cycle();
    chk("mis_addr", 32'(imem_addr), 32'h10);
    chk("mis_valid", 32'(id_valid), 32'd0);
    chk("mis_flag", 32'(misalign), 32'd1);
    idle(); repeat (3) cycle();
    chk("mis_sticky", 32'(misalign), 32'd1);
    halt_req = 1; cycle();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_valid", 32'(id_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      stall = i[0]; flush = i[1]; halt_req = i[2]; cycle();
    end
    idle(); redirect = 1; redirect_pc = 32'h100; cycle();
    chk("unhalt", 32'(halted), 32'd0);
    idle(); cycle();
    chk("unhalt_pc4", id_pc4, 32'h104);
    redirect = 1; redirect_pc = 32'hFFFF_FFFC; cycle();
    idle(); cycle();
    chk("wrap_pc4", id_pc4, 32'd0);
    chk("wrap_addr", 32'(imem_addr), 32'd0);
    flush = 1; stall = 1; cycle();
    chk("fs_valid", 32'(id_valid), 32'd0);
    chk("fs_addr", 32'(imem_addr), 32'd0);
    idle(); halt_req = 1; cycle(); idle(); cycle();
    async_reset();
    cycle();
    chk("reboot_valid", 32'(id_valid), 32'd0);
    cycle();
    chk("reboot_instr", id_instr, 32'd0);
    chk("reboot_count", fetch_count, 32'd1);
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int c = 0; c < 4000; c++) begin
      stall       = ($urandom_range(99) < 20);
      flush       = ($urandom_range(99) < 10);
      redirect    = ($urandom_range(99) < 8);
      halt_req    = ($urandom_range(99) < 3);
      redirect_pc = $urandom;
      if ($urandom_range(499) == 0) begin
        idle(); async_reset();
      end
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
